// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the two-port block-refill memory arbiter.
package mem_arb_pkg;

  localparam int MEM_ARB_PORTS     = 2;
  localparam int MEM_ARB_BURST_LEN = 4;

  function automatic int beat_width(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

  localparam int BEAT_W = beat_width(MEM_ARB_BURST_LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } mem_arb_state_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester and memory-side signals of the arbiter; master = arbiter, slave = requesters/memory.
interface mem_req_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [MEM_ARB_PORTS-1:0]            req_valid;
  logic [MEM_ARB_PORTS-1:0]            req_ready;
  logic [MEM_ARB_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [MEM_ARB_PORTS-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]               rsp_data;
  logic                                rsp_last;
  logic                                mem_req_valid;
  logic [ADDR_WIDTH-1:0]               mem_req_addr;
  logic                                mem_req_ready;
  logic [DATA_WIDTH-1:0]               mem_req_rdata;

  modport master (
    input  req_valid, req_addr, mem_req_ready, mem_req_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_last, mem_req_valid, mem_req_addr
  );

  modport slave (
    output req_valid, req_addr, mem_req_ready, mem_req_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_last, mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/mem_req_arbiter_pick.sv
// Combinational 2-way one-hot grant; i_prio names the port that wins when both request.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [MEM_ARB_PORTS-1:0] i_req_valid,
  input  logic                     i_prio,
  output logic [MEM_ARB_PORTS-1:0] o_grant
);

  always_comb begin
    o_grant = '0;
    case (i_req_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_prio ? 2'b10 : 2'b01;
      default: o_grant = '0;
    endcase
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Grants one block burst of BURST_LEN word reads to one of two requesters; responses return 1 cycle after each memory ready.
// Optional MEM_ARB_ROUND_ROBIN_EN alternates priority after each burst; otherwise port 0 has fixed priority.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST_LEN  = MEM_ARB_BURST_LEN,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_arbiter_if.master io
);

  localparam int                     BEAT_BITS = beat_width(BURST_LEN);
  localparam int                     LOW_BITS  = $clog2(BURST_LEN) + 2;
  localparam logic [BEAT_BITS-1:0]   LAST_BEAT = BEAT_BITS'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0]  BASE_MASK = {ADDR_WIDTH{1'b1}} << LOW_BITS;

  mem_arb_state_t                r_state;
  logic                          r_owner;
  logic [BEAT_BITS-1:0]          r_beat;
  logic [ADDR_WIDTH-1:0]         r_base;
  logic [ADDR_WIDTH-1:0]         r_mem_addr;
  logic                          r_mem_valid;
  logic [MEM_ARB_PORTS-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0]         r_rsp_data;
  logic                          r_rsp_last;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                          r_rr;
`endif

  logic                          w_prio;
  logic [MEM_ARB_PORTS-1:0]      w_pick;
  logic [MEM_ARB_PORTS-1:0]      w_grant;
  logic [ADDR_WIDTH-1:0]         w_sel_addr;
  logic [ADDR_WIDTH-1:0]         w_next_addr;
  logic [BEAT_BITS-1:0]          w_next_beat;
  logic                          w_last_beat;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_prio = r_rr;
`else
  assign w_prio = 1'b0;
`endif

  mem_arb_pick u_pick (
    .i_req_valid (io.req_valid),
    .i_prio      (w_prio),
    .o_grant     (w_pick)
  );

  // Grant is gated by reset so every output reads 0 the moment reset asserts.
  assign w_grant     = (r_state == IDLE && !reset) ? w_pick : '0;
  assign w_sel_addr  = w_grant[1] ? io.req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                  : io.req_addr[0 +: ADDR_WIDTH];
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_next_beat = r_beat + 1'b1;
  // Base has the beat field cleared, so OR-ing the offset can never carry upward.
  assign w_next_addr = r_base | ADDR_WIDTH'({w_next_beat, 2'b00});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_beat      <= '0;
      r_base      <= '0;
      r_mem_addr  <= '0;
      r_mem_valid <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_rr        <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= '0;
      r_rsp_last  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_owner     <= w_grant[1];
            r_base      <= w_sel_addr & BASE_MASK;
            r_mem_addr  <= w_sel_addr & BASE_MASK;
            r_beat      <= '0;
            r_mem_valid <= 1'b1;
            r_state     <= BURST;
          end
        end
        BURST: begin
          if (io.mem_req_ready) begin
            r_rsp_data  <= io.mem_req_rdata;
            r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            r_rsp_last  <= w_last_beat;
            if (w_last_beat) begin
              r_state     <= IDLE;
              r_mem_valid <= 1'b0;
              r_mem_addr  <= '0;
              r_beat      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
              r_rr        <= ~r_owner;
`endif
            end else begin
              r_beat      <= w_next_beat;
              r_mem_addr  <= w_next_addr;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io.req_ready     = w_grant;
  assign io.rsp_valid     = r_rsp_valid;
  assign io.rsp_data      = r_rsp_data;
  assign io.rsp_last      = r_rsp_last;
  assign io.mem_req_valid = r_mem_valid;
  assign io.mem_req_addr  = r_mem_addr;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: a small memory model answers beats, expectations are queued at request time.
module tb_mem_req_arbiter;

  localparam int BL = 4;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] dat;
    logic        last;
  } rsp_t;

  logic clk;
  logic reset;

  mem_req_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

  mem_req_arbiter #(.BURST_LEN(BL), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rsp    = 0;
  int   n_any    = 0;
  int   n_last   = 0;
  int   beats_rdy = 0;
  int   vld_cycles = 0;
  int   wait_cycles = 0;
  bit   force_rdy = 1'b0;
  bit   prev_beat = 1'b0;
  rsp_t        exp_rsp_q[$];
  logic [31:0] exp_addr_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h9C;
  endfunction

  // Memory model and response monitor share one process so their ordering is fixed.
  initial begin
    int wcnt;
    rsp_t e;
    wcnt = 0;
    mif.mem_req_ready = 1'b0;
    mif.mem_req_rdata = '0;
    forever begin
      @(negedge clk);
      if (mif.rsp_valid != 2'b00) begin
        n_any++;
        chk("rsp_lag", {63'd0, prev_beat}, 64'd1);
        if (exp_rsp_q.size() == 0) begin
          chk("rsp_unexpected", {62'd0, mif.rsp_valid}, 64'd0);
        end else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_port", {62'd0, mif.rsp_valid}, {62'd0, e.vld});
          chk("rsp_data", {32'd0, mif.rsp_data}, {32'd0, e.dat});
          chk("rsp_last", {63'd0, mif.rsp_last}, {63'd0, e.last});
          n_rsp++;
          if (mif.rsp_last) n_last++;
        end
      end else begin
        chk("last_wo_valid", {63'd0, mif.rsp_last}, 64'd0);
      end

      if (reset) begin
        mif.mem_req_ready = 1'b0;
        wcnt = 0;
      end else if (mif.mem_req_valid) begin
        vld_cycles++;
        if (exp_addr_q.size() == 0)
          chk("addr_unexpected", 64'(exp_addr_q.size()), 64'd1);
        else
          chk("beat_addr", {32'd0, mif.mem_req_addr}, {32'd0, exp_addr_q[0]});
        if (wcnt == wait_cycles) begin
          mif.mem_req_ready = 1'b1;
          mif.mem_req_rdata = mem_word(mif.mem_req_addr);
          wcnt = 0;
          beats_rdy++;
          if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
        end else begin
          mif.mem_req_ready = force_rdy;
          mif.mem_req_rdata = 32'hDEAD_0000;
          wcnt++;
        end
      end else begin
        mif.mem_req_ready = force_rdy;
        mif.mem_req_rdata = 32'hBAD0_0000;
        wcnt = 0;
      end
      prev_beat = mif.mem_req_valid && mif.mem_req_ready && !reset;
    end
  end

  task automatic push_burst(input int p, input logic [31:0] addr);
    logic [31:0] base;
    rsp_t r;
    base = addr & ~32'(BL * 4 - 1);
    for (int k = 0; k < BL; k++) begin
      exp_addr_q.push_back(base + 32'(k * 4));
      r.vld  = 2'(1 << p);
      r.dat  = mem_word(base + 32'(k * 4));
      r.last = (k == BL - 1);
      exp_rsp_q.push_back(r);
    end
  endtask

  task automatic issue(input int p, input logic [31:0] addr);
    int n;
    @(negedge clk); #1;
    push_burst(p, addr);
    mif.req_addr[p*32 +: 32] = addr;
    mif.req_valid[p] = 1'b1;
    #1;
    chk("grant_immediate", {62'd0, mif.req_ready}, 64'(1 << p));
    n = 0;
    while (!mif.req_ready[p] && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!mif.req_ready[p]) chk("grant_timeout", {63'd0, mif.req_ready[p]}, 64'd1);
    @(posedge clk); #1;
    mif.req_valid[p] = 1'b0;
    mif.req_addr[p*32 +: 32] = 32'hDEAD_BEEF;
    chk("vld_after_hs", {63'd0, mif.mem_req_valid}, 64'd1);
    chk("rdy_in_burst", {62'd0, mif.req_ready}, 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_rsp_q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_rsp", 64'(exp_rsp_q.size()), 64'd0);
    chk("drain_addr", 64'(exp_addr_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, {62'd0, mif.req_ready}, 64'd0);
    chk({tag, "_rsp_valid"}, {62'd0, mif.rsp_valid}, 64'd0);
    chk({tag, "_rsp_last"}, {63'd0, mif.rsp_last}, 64'd0);
    chk({tag, "_rsp_data"}, {32'd0, mif.rsp_data}, 64'd0);
    chk({tag, "_mem_vld"}, {63'd0, mif.mem_req_valid}, 64'd0);
    chk({tag, "_mem_addr"}, {32'd0, mif.mem_req_addr}, 64'd0);
  endtask

  initial begin
    int n, n0, na, v0, b0;
    reset = 1'b1;
    mif.req_valid = '0;
    mif.req_addr  = '0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("rst");
    reset = 1'b0;

    // Port 0 alone, zero-wait memory, unaligned address.
    v0 = vld_cycles;
    issue(0, 32'h0000_0013);
    drain();
    chk("burst_cycles", 64'(vld_cycles - v0), 64'(BL));

    // Two wait cycles per beat: address must hold while ready is low.
    wait_cycles = 2;
    v0 = vld_cycles;
    issue(0, 32'h0000_0088);
    drain();
    chk("wait_burst_cycles", 64'(vld_cycles - v0), 64'(BL * 3));
    wait_cycles = 0;

    // Memory ready while idle must be ignored.
    na = n_any;
    force_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    force_rdy = 1'b0;
    chk("idle_rdy_vld", {63'd0, mif.mem_req_valid}, 64'd0);
    @(negedge clk); #1;
    chk("idle_rdy_rsp", 64'(n_any - na), 64'd0);
    issue(1, 32'h0000_0024);
    drain();

    // Reset during beat 3 of a port-1 burst.
    n0 = n_rsp;
    issue(1, 32'h0000_0040);
    n = 0;
    while (n_rsp < n0 + 3 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rst_mid_reach", 64'(n_rsp - n0), 64'd3);
    na = n_any;
    mif.req_valid = 2'b01;
    reset = 1'b1;
    #1;
    chk("rst_mid_req_ready", {62'd0, mif.req_ready}, 64'd0);
    chk("rst_mid_mem_vld", {63'd0, mif.mem_req_valid}, 64'd0);
    chk("rst_mid_mem_addr", {32'd0, mif.mem_req_addr}, 64'd0);
    chk("rst_mid_rsp_vld", {62'd0, mif.rsp_valid}, 64'd0);
    chk("rst_mid_rsp_last", {63'd0, mif.rsp_last}, 64'd0);
    exp_rsp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_no_beat3", 64'(n_any - na), 64'd0);
    mif.req_valid = '0;
    reset = 1'b0;
    issue(1, 32'h0000_0040);
    drain();

    // Both ports held valid for three bursts.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_burst(0, 32'h100);
    push_burst(1, 32'h200);
    push_burst(0, 32'h100);
`else
    push_burst(0, 32'h100);
    push_burst(0, 32'h100);
    push_burst(0, 32'h100);
`endif
    mif.req_addr  = {32'h0000_0200, 32'h0000_0100};
    mif.req_valid = 2'b11;
    n0 = n_last;
    n = 0;
    while (n_last < n0 + 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    mif.req_valid = '0;
    chk("both_bursts", 64'(n_last - n0), 64'd3);
    drain();

    // Port 0 requests during port 1's final beat.
    issue(1, 32'h0000_0300);
    b0 = beats_rdy;
    n = 0;
    while (beats_rdy < b0 + BL && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    push_burst(0, 32'h0000_0500);
    mif.req_addr[31:0] = 32'h0000_0500;
    mif.req_valid[0]   = 1'b1;
    #1;
    chk("final_beat_no_grant", {62'd0, mif.req_ready}, 64'd0);
    @(negedge clk); #1;
    chk("grant_after_burst", {62'd0, mif.req_ready}, 64'd1);
    chk("last_coincides", {63'd0, mif.rsp_last}, 64'd1);
    @(posedge clk); #1;
    mif.req_valid = '0;
    chk("next_first_vld", {63'd0, mif.mem_req_valid}, 64'd1);
    chk("next_first_addr", {32'd0, mif.mem_req_addr}, 64'h500);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares the single backing-memory request port between two block-refill requesters: port 0 is the uncompressed cache controller and port 1 is the compressed-cache/dictionary refill path. Each grant covers one full block burst of BURST_LEN word reads with incrementing addresses. The block returns each word to the owning requester as a registered response pulse. It sits between the cache controllers and the memory model/bus that drives `mem_req_ready`/`mem_req_rdata`.

## Interface
- `BURST_LEN`, default 4: words per block refill; power of two, ≥1.
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: word width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 2: refill request per port.
- `req_ready` out 2: grant/accept; handshake completes on `req_valid[i] & req_ready[i]` at a rising edge.
- `req_addr` in 2*ADDR_WIDTH: packed request addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `rsp_valid` out 2: one-cycle pulse per returned word, to the owning port.
- `rsp_data` out DATA_WIDTH: returned word, shared by both ports.
- `rsp_last` out 1: qualifies the final word of a burst.
- `mem_req_valid` out 1: beat request to memory.
- `mem_req_addr` out ADDR_WIDTH: beat address.
- `mem_req_ready` in 1: memory completes the beat this cycle; data is on `mem_req_rdata`.
- `mem_req_rdata` in DATA_WIDTH: beat data, valid while `mem_req_ready` is high.

## Operation
- States:
  - IDLE: no burst in progress.
  - BURST: issuing beats for the granted port.
- Reset values: all outputs 0; state IDLE; beat counter 0; rr pointer 0; owner 0.
- IDLE:
  - `req_ready` is combinational: a one-hot grant to the winner of the valid requests; 0 if none are valid.
  - On handshake: latch owner and base address, clear the beat counter, go to BURST.
  - Base address = `req_addr` with the low log2(BURST_LEN)+2 bits cleared.
- BURST:
  - `mem_req_valid`=1.
  - `mem_req_addr` = base | (beat<<2). The beat field never carries into upper address bits.
  - `req_ready`=0 on both ports.
- On each `mem_req_ready` in BURST:
  - Register `mem_req_rdata` into `rsp_data`.
  - Assert `rsp_valid[owner]` next cycle.
  - Set `rsp_last` next cycle if beat==BURST_LEN-1.
  - Increment beat.
- After the final beat: return to IDLE and update the arbitration pointer.
- `mem_req_ready` outside BURST is ignored; no response is generated.
- Requesters cannot stall responses. `rsp_valid` is a pulse and must be consumed that cycle.
- A requester may drop `req_valid` before grant without effect. `req_addr` is sampled only at the handshake.
- Reset asserted mid-burst:
  - Immediate return to IDLE with all outputs 0.
  - The partial burst is abandoned; no further `rsp_valid`.
  - Any beat in flight at memory is dropped.

## Timing
- Handshake at edge t → `mem_req_valid` high from cycle t+1.
- Zero-wait memory (`mem_req_ready` high every cycle in BURST): one beat per cycle; BURST lasts exactly BURST_LEN cycles.
- `rsp_valid` lags the matching `mem_req_ready` by exactly 1 cycle.
- `mem_req_addr` advances in the cycle after each `mem_req_ready`. It is stable while `mem_req_ready` is low.
- After the last beat, the block spends at least one IDLE cycle before the next grant. Minimum request-to-request spacing is BURST_LEN+1 cycles.
- The final `rsp_valid`/`rsp_last` may coincide with the next grant's `req_ready`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - 1-bit rr pointer gives priority to port rr when both ports are valid.
  - On burst completion for port i, the pointer is set to 1-i.
  - A single requester is always granted regardless of pointer.
- Undefined:
  - Fixed priority, port 0 wins when both are valid.
  - Pointer logic is absent.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum (IDLE, BURST).
  - `BEAT_W` = max(1, $clog2(BURST_LEN)).
  - Port-count constant `MEM_ARB_PORTS`=2.
- One sub-module, `mem_arb_pick`: combinational 2-way grant from `req_valid` and priority bit, one-hot output. Under fixed priority it is driven with priority 0.

## Test plan
- Port 0 only, addr 0x0000_0013, zero-wait memory returning 0xA0..0xA3:
  - `mem_req_addr` = 0x10, 0x14, 0x18, 0x1C on consecutive cycles.
  - `rsp_valid[0]` pulses 4 cycles with data A0..A3; `rsp_last` on A3; `rsp_valid[1]` stays 0.
- Both ports valid together, port 0 addr 0x100, port 1 addr 0x200, held valid:
  - With `MEM_ARB_ROUND_ROBIN_EN`: bursts alternate 0x100, 0x200, 0x100.
  - Without it: port 0 is repeatedly granted and port 1 starves.
- Memory inserts 2 wait cycles per beat (`mem_req_ready` every 3rd cycle):
  - `mem_req_addr` holds each beat address across the wait cycles.
  - 4 responses total, each 1 cycle after its ready pulse.
- `mem_req_ready` pulsed while IDLE, no request pending: no `rsp_valid`, state stays IDLE.
- Reset asserted after beat 2 of a port-1 burst at 0x40:
  - All outputs go 0 immediately; no beat-3 response.
  - After release, a port-1 request at 0x40 restarts from beat 0 (addr 0x40).
- Port 0 raises `req_valid` during port-1's final beat: port 0 is granted in the first IDLE cycle after the burst ends, and its first beat address appears next cycle.
